// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit.
//   - lsu_state_t : FSM states (IDLE, BUSY, DONE)
//   - LD_*        : load formats as {Ext_Data_Src, Ext_Data_Val}
//   - ST_*        : store sizes as Ext_rs2_Src
//   - size_t      : access width after decoding either format
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    // Any format with bit 2 clear is a word load; LD_WORD is the canonical one.
    localparam logic [2:0] LD_WORD = 3'b000;
    localparam logic [2:0] LD_B    = 3'b111;
    localparam logic [2:0] LD_H    = 3'b110;
    localparam logic [2:0] LD_BU   = 3'b101;
    localparam logic [2:0] LD_HU   = 3'b100;

    localparam logic [1:0] ST_B = 2'b10;
    localparam logic [1:0] ST_H = 2'b01;
    localparam logic [1:0] ST_W = 2'b00;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    function automatic size_t load_size(logic [2:0] fmt);
        if (!fmt[2]) return SZ_W;
        return fmt[0] ? SZ_B : SZ_H;
    endfunction

    // The reserved encoding 2'b11 falls through to a word store.
    function automatic size_t store_size(logic [1:0] st);
        case (st)
            ST_B:    return SZ_B;
            ST_H:    return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load lane select and sign/zero extension.
//   mem_rdata : raw 32-bit bus word
//   addr_lo   : byte offset of the access within the word
//   fmt       : load format {Ext_Data_Src, Ext_Data_Val}
//   result    : extended load value
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  fmt,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = mem_rdata[{addr_lo, 3'b000} +: 8];
        half_lane = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (fmt)
            LD_B:    result = {{24{byte_lane[7]}}, byte_lane};
            LD_BU:   result = {24'd0, byte_lane};
            LD_H:    result = {{16{half_lane[15]}}, half_lane};
            LD_HU:   result = {16'd0, half_lane};
            default: result = mem_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one core memory instruction into one handshaked bus
// transaction, stalls the core until it completes, and traps misaligned accesses.
//   clk, rst              : clock, async active-high reset
//   req_valid, MemRead,
//   MemWrite              : core request (store wins if both set)
//   Ext_Data_Val/Src      : load format;  Ext_rs2_Src : store size
//   addr, wdata           : byte address and rs2 value
//   stall, done, misalign : core handshake and trap pulse
//   rdata                 : last extended load value
//   mem_*                 : data-memory bus (req/ack handshake)
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        Ext_Data_Val,
    input  logic              Ext_Data_Src,
    input  logic [1:0]        Ext_rs2_Src,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic              done,
    output logic              misalign,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_t        state;
    logic [2:0]        ld_fmt;
    logic [2:0]        fmt_q;
    logic [1:0]        addr_lo_q;
    logic              start;
    logic              is_store;
    size_t             size;
    logic              misaligned;
    logic [3:0]        be_req;
    logic [DATA_W-1:0] wdata_req;
    logic [DATA_W-1:0] ext_data;

    assign ld_fmt   = {Ext_Data_Src, Ext_Data_Val};
    assign start    = req_valid & (MemRead | MemWrite);
    assign is_store = MemWrite;

    always_comb begin
        size       = is_store ? store_size(Ext_rs2_Src) : load_size(ld_fmt);
        misaligned = ((size == SZ_H) & addr[0]) | ((size == SZ_W) & (addr[1:0] != 2'b00));
        be_req     = 4'b1111;
        wdata_req  = wdata;
        case (size)
            SZ_B: begin
                be_req    = 4'b0001 << addr[1:0];
                wdata_req = {4{wdata[7:0]}};
            end
            SZ_H: begin
                be_req    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_req = {2{wdata[15:0]}};
            end
            default: ;
        endcase
        if (!is_store) wdata_req = '0;
    end

    load_extend u_load_extend (
        .mem_rdata (mem_rdata),
        .addr_lo   (addr_lo_q),
        .fmt       (fmt_q),
        .result    (ext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
            fmt_q     <= LD_WORD;
            addr_lo_q <= 2'b00;
            rdata     <= '0;
            misalign  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    misalign <= 1'b0;
                    if (start) begin
                        if (misaligned) begin
                            // Trap without touching the bus.
                            state    <= DONE;
                            misalign <= 1'b1;
                        end else begin
                            state     <= BUSY;
                            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            mem_we    <= is_store;
                            mem_be    <= be_req;
                            mem_wdata <= wdata_req;
                            fmt_q     <= ld_fmt;
                            addr_lo_q <= addr[1:0];
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        state <= DONE;
                        if (!mem_we) rdata <= ext_data;
                    end
                end
                DONE: begin
                    // The core still presents the finished instruction here.
                    state    <= IDLE;
                    misalign <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gated by rst so a still-presented request cannot hold stall high in reset.
    assign stall   = ~rst & (((state == IDLE) & start) | (state == BUSY));
    assign done    = (state == DONE);
    assign mem_req = (state == BUSY);

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk, rst;
    logic        req_valid, MemRead, MemWrite, Ext_Data_Src;
    logic [1:0]  Ext_Data_Val, Ext_rs2_Src;
    logic [31:0] addr, wdata;
    logic        stall, done, misalign, mem_req, mem_we, mem_ack;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .MemRead(MemRead), .MemWrite(MemWrite),
        .Ext_Data_Val(Ext_Data_Val), .Ext_Data_Src(Ext_Data_Src), .Ext_rs2_Src(Ext_rs2_Src),
        .addr(addr), .wdata(wdata), .stall(stall), .done(done), .misalign(misalign),
        .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } bus_exp_t;
    typedef struct { logic mis; logic [31:0] rdata; int cyc; } done_exp_t;
    typedef struct { int delay; logic [31:0] data; } resp_t;

    bus_exp_t  exp_bus[$];
    done_exp_t exp_done[$];
    resp_t     resp_q[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic        auto_resp = 0;
    logic [31:0] model_rdata = 0;

    initial begin clk = 0; forever #5 clk = ~clk; end
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus responder: serves planned responses, throws stray acks when the bus is idle.
    initial begin
        resp_t r;
        mem_ack = 0; mem_rdata = 0;
        forever begin
            @(negedge clk);
            if (auto_resp) begin
                mem_ack = 0; mem_rdata = $urandom;
                if (mem_req) begin
                    if (resp_q.size() == 0) begin
                        check("resp_planned", 32'd0, 32'd1);
                    end else begin
                        r = resp_q.pop_front();
                        repeat (r.delay) begin @(negedge clk); mem_rdata = $urandom; end
                        mem_ack = 1; mem_rdata = r.data;
                    end
                end else begin
                    mem_ack = ($urandom_range(0, 3) == 0);
                end
            end
        end
    end

    // Monitor: compares bus requests and completions against the scoreboard queues.
    bus_exp_t  cur_bus;
    done_exp_t cur_done;
    logic      bus_seen = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req) begin
                if (!bus_seen) begin
                    if (exp_bus.size() == 0) begin
                        check("unexpected_req", 32'd1, 32'd0);
                    end else begin
                        cur_bus = exp_bus.pop_front();
                        check("mem_addr", mem_addr, cur_bus.addr);
                        check("mem_we", 32'(mem_we), 32'(cur_bus.we));
                        check("mem_be", 32'(mem_be), 32'(cur_bus.be));
                        check("mem_wdata", mem_wdata, cur_bus.wdata);
                    end
                    bus_seen = 1;
                end else begin
                    check("bus_stable", 32'(mem_addr === cur_bus.addr && mem_we === cur_bus.we
                          && mem_be === cur_bus.be && mem_wdata === cur_bus.wdata), 32'd1);
                end
            end else begin
                bus_seen = 0;
            end
            if (misalign && !done) check("misalign_without_done", 32'd1, 32'd0);
            if (done) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    cur_done = exp_done.pop_front();
                    check("misalign", 32'(misalign), 32'(cur_done.mis));
                    check("rdata", rdata, cur_done.rdata);
                    check("done_cycle", 32'(cyc), 32'(cur_done.cyc));
                    check("stall_at_done", 32'(stall), 32'd0);
                end
            end
        end
    end

    // Reference model plus driver for one access. st/rd are MemWrite/MemRead.
    task automatic access(input logic st, input logic rd, input logic [2:0] fmt,
                          input logic [1:0] ssz, input logic [31:0] a, input logic [31:0] w,
                          input int delay, input logic [31:0] bus_data);
        int          nbytes, off, c0;
        logic        mis, sgn;
        logic [31:0] mask, val, wexp;
        logic [3:0]  be;
        bit          got;
        if (st) nbytes = (ssz == 2'b10) ? 1 : (ssz == 2'b01) ? 2 : 4;
        else    nbytes = !fmt[2] ? 4 : fmt[0] ? 1 : 2;
        off  = int'(a % 4);
        mis  = (a % nbytes) != 0;
        be   = 4'(((1 << nbytes) - 1) << off);
        wexp = !st ? 32'd0 : (nbytes == 1) ? w[7:0] * 32'h0101_0101
             : (nbytes == 2) ? w[15:0] * 32'h0001_0001 : w;
        if (!st && !mis) begin
            mask = (nbytes == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nbytes)) - 1;
            val  = (bus_data >> (8 * off)) & mask;
            sgn  = fmt[2] && fmt[1];
            if (sgn && val[8 * nbytes - 1]) val = val | ~mask;
            model_rdata = val;
        end
        @(negedge clk);
        req_valid = 1; MemWrite = st; MemRead = rd;
        Ext_Data_Src = fmt[2]; Ext_Data_Val = fmt[1:0]; Ext_rs2_Src = ssz;
        addr = a; wdata = w;
        c0 = cyc;
        if (!mis) begin
            exp_bus.push_back('{addr: a & 32'hFFFF_FFFC, we: st, be: be, wdata: wexp});
            resp_q.push_back('{delay: delay, data: bus_data});
        end
        exp_done.push_back('{mis: mis, rdata: model_rdata, cyc: mis ? c0 + 1 : c0 + 2 + delay});
        #1 check("stall_on_accept", 32'(stall), 32'd1);
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
            else if (!stall) check("stall_while_busy", 32'(stall), 32'd1);
        end
        if (!got) check("done_timeout", 32'd0, 32'd1);
        req_valid = 0; MemRead = 0; MemWrite = 0;
    endtask

    initial begin
        logic [2:0]  fmt;
        logic [1:0]  ssz;
        logic [31:0] a;
        int          op;
        rst = 1; req_valid = 0; MemRead = 0; MemWrite = 0;
        Ext_Data_Src = 0; Ext_Data_Val = 0; Ext_rs2_Src = 0; addr = 0; wdata = 0;
        repeat (2) @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_outs", {mem_addr[29:0], mem_we, misalign} | mem_wdata | 32'(mem_be), 32'd0);
        rst = 0; auto_resp = 1;

        // Directed cases
        access(1, 0, 3'b000, 2'b00, 32'h100, 32'hDEAD_BEEF, 0, 32'h0);      // SW
        access(1, 0, 3'b000, 2'b10, 32'h203, 32'h1234_5678, 1, 32'h0);      // SB
        access(0, 1, 3'b111, 2'b00, 32'h101, 32'h0, 0, 32'h0000_8000);      // LB
        access(0, 1, 3'b101, 2'b00, 32'h101, 32'h0, 2, 32'h0000_8000);      // LBU
        access(0, 1, 3'b110, 2'b00, 32'h102, 32'h0, 5, 32'h9ABC_0000);      // LH
        access(0, 1, 3'b000, 2'b00, 32'h102, 32'h0, 0, 32'h0);              // LW misaligned
        access(1, 1, 3'b000, 2'b01, 32'h305, 32'h0, 0, 32'h0);              // SH misaligned
        access(1, 0, 3'b000, 2'b11, 32'h400, 32'hCAFE_F00D, 0, 32'h0);      // reserved -> SW

        // Reset while BUSY, then a stray ack
        auto_resp = 0; mem_ack = 0;
        @(negedge clk);
        req_valid = 1; MemRead = 1; MemWrite = 0;
        Ext_Data_Src = 0; Ext_Data_Val = 0; addr = 32'h500;
        exp_bus.push_back('{addr: 32'h500, we: 1'b0, be: 4'hF, wdata: 32'h0});
        repeat (2) @(negedge clk);
        #2 rst = 1;
        #1;
        check("arst_mem_req", 32'(mem_req), 32'd0);
        check("arst_stall", 32'(stall), 32'd0);
        check("arst_rdata", rdata, 32'd0);
        check("arst_outs", {mem_addr[29:0], mem_we, done} | mem_wdata | 32'(mem_be), 32'd0);
        req_valid = 0; MemRead = 0;
        @(negedge clk); rst = 0; model_rdata = 0;
        exp_done.delete(); resp_q.delete();
        mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk); mem_ack = 0;
        repeat (3) begin
            check("stray_ack_done", 32'(done | mem_req), 32'd0);
            @(negedge clk);
        end
        auto_resp = 1;

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            op  = $urandom_range(0, 2);
            fmt = 3'($urandom);
            ssz = 2'($urandom);
            a   = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            access(op != 0, op != 1, fmt, ssz, a, $urandom, $urandom_range(0, 4), $urandom);
        end

        repeat (4) @(negedge clk);
        check("queues_drained", 32'(exp_bus.size() + exp_done.size() + resp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
